// File: rtl/pixel_ctrl_pkg.sv
// Shared types and constants for the pixel array frame sequencer.
package pixel_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StErase,
    StExpose,
    StConvert,
    StRead1,
    StRead2
  } state_e;

  localparam int unsigned CntWDefault   = 8;
  localparam int unsigned EraseCycDef   = 5;
  localparam int unsigned ConvCycDef    = 255;
  localparam int unsigned ReadCycDef    = 4;
  localparam int unsigned ExpMinDef     = 2;
  localparam int unsigned ExpMaxDef     = 30;
  localparam int unsigned ExpDefaultDef = 16;

  // Number of cycles spent in a state; IDLE reports 1 so the counter loads zero.
  function automatic int unsigned phase_cycles(input state_e      st,
                                               input int unsigned exp_cyc,
                                               input int unsigned erase_cyc,
                                               input int unsigned conv_cyc,
                                               input int unsigned read_cyc);
    int unsigned cyc;
    cyc = 1;
    unique case (st)
      StErase:   cyc = erase_cyc;
      StExpose:  cyc = exp_cyc;
      StConvert: cyc = conv_cyc;
      StRead1:   cyc = read_cyc;
      StRead2:   cyc = read_cyc;
      default:   cyc = 1;
    endcase
    return cyc;
  endfunction

endpackage

// File: rtl/pixel_controller_if.sv
// Control inputs and pixel strobe outputs of the frame sequencer.
interface pixel_controller_if #(
  parameter int unsigned CNT_W = 8
);
  logic             Init;
  logic             Exp_increase;
  logic             Exp_decrease;
  logic             Erase;
  logic             Expose;
  logic             ADC;
  logic             NRE_1;
  logic             NRE_2;
  logic             Busy;
  logic             Frame_done;
  logic [CNT_W-1:0] Exp_time;

  // Camera top-level side.
  modport master (
    output Init, Exp_increase, Exp_decrease,
    input  Erase, Expose, ADC, NRE_1, NRE_2, Busy, Frame_done, Exp_time
  );

  // Sequencer side.
  modport slave (
    input  Init, Exp_increase, Exp_decrease,
    output Erase, Expose, ADC, NRE_1, NRE_2, Busy, Frame_done, Exp_time
  );
endinterface

// File: rtl/exposure_reg.sv
// Saturating up/down exposure-time register; only moves while en_i is high.
module exposure_reg #(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned EXP_MIN     = 2,
  parameter int unsigned EXP_MAX     = 30,
  parameter int unsigned EXP_DEFAULT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] exp_o
);

  localparam logic [CNT_W-1:0] MinV = CNT_W'(EXP_MIN);
  localparam logic [CNT_W-1:0] MaxV = CNT_W'(EXP_MAX);
  localparam logic [CNT_W-1:0] RstV = CNT_W'(EXP_DEFAULT);

  logic [CNT_W-1:0] exp_q, exp_d;

  always_comb begin
    exp_d = exp_q;
    if (en_i && inc_i && !dec_i && (exp_q < MaxV)) begin
      exp_d = exp_q + CNT_W'(1);
    end else if (en_i && dec_i && !inc_i && (exp_q > MinV)) begin
      exp_d = exp_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_q <= RstV;
    end else begin
      exp_q <= exp_d;
    end
  end

  assign exp_o = exp_q;

endmodule

// File: rtl/pixel_controller.sv
// Frame sequencer: erase, expose, convert, read bank 1, read bank 2 per Init request.
module pixel_controller
  import pixel_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W       = CntWDefault,
  parameter int unsigned ERASE_CYC   = EraseCycDef,
  parameter int unsigned CONV_CYC    = ConvCycDef,
  parameter int unsigned READ_CYC    = ReadCycDef,
  parameter int unsigned EXP_MIN     = ExpMinDef,
  parameter int unsigned EXP_MAX     = ExpMaxDef,
  parameter int unsigned EXP_DEFAULT = ExpDefaultDef
) (
  input logic                clk,
  input logic                reset,
  pixel_controller_if.slave  bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] exp_lat_q, exp_lat_d;
  logic [CNT_W-1:0] exp_time;
  logic             erase_q, erase_d, expose_q, expose_d, adc_q, adc_d;
  logic             nre1_q, nre1_d, nre2_q, nre2_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             phase_end;

  exposure_reg #(
    .CNT_W       (CNT_W),
    .EXP_MIN     (EXP_MIN),
    .EXP_MAX     (EXP_MAX),
    .EXP_DEFAULT (EXP_DEFAULT)
  ) u_exposure_reg (
    .clk   (clk),
    .reset (reset),
    .en_i  (state_q == StIdle),
    .inc_i (bus.Exp_increase),
    .dec_i (bus.Exp_decrease),
    .exp_o (exp_time)
  );

  assign phase_end = (cnt_q == '0);

  always_comb begin
    state_d   = state_q;
    exp_lat_d = exp_lat_q;
    unique case (state_q)
      StIdle: begin
        if (bus.Init) begin
          state_d   = StErase;
          // Capture the pre-update value in case an exposure step lands on this edge.
          exp_lat_d = exp_time;
        end
      end
      StErase:   if (phase_end) state_d = StExpose;
      StExpose:  if (phase_end) state_d = StConvert;
      StConvert: if (phase_end) state_d = StRead1;
      StRead1:   if (phase_end) state_d = StRead2;
      StRead2:   if (phase_end) state_d = StIdle;
      default:   state_d = StIdle;
    endcase

    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = CNT_W'(phase_cycles(state_d, 32'(exp_lat_q), ERASE_CYC, CONV_CYC, READ_CYC) - 1);
    end else if (!phase_end) begin
      cnt_d = cnt_q - CNT_W'(1);
    end

    // Strobes decode from next state so they switch on the same edge as the state.
    erase_d  = (state_d == StIdle) || (state_d == StErase);
    expose_d = (state_d == StExpose);
    adc_d    = (state_d == StConvert);
    nre1_d   = (state_d != StRead1);
    nre2_d   = (state_d != StRead2);
    busy_d   = (state_d != StIdle);
    done_d   = (state_q == StRead2) && (state_d == StIdle);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      exp_lat_q <= CNT_W'(EXP_DEFAULT);
      erase_q   <= 1'b1;
      expose_q  <= 1'b0;
      adc_q     <= 1'b0;
      nre1_q    <= 1'b1;
      nre2_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      exp_lat_q <= exp_lat_d;
      erase_q   <= erase_d;
      expose_q  <= expose_d;
      adc_q     <= adc_d;
      nre1_q    <= nre1_d;
      nre2_q    <= nre2_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.Erase      = erase_q;
  assign bus.Expose     = expose_q;
  assign bus.ADC        = adc_q;
  assign bus.NRE_1      = nre1_q;
  assign bus.NRE_2      = nre2_q;
  assign bus.Busy       = busy_q;
  assign bus.Frame_done = done_q;
  assign bus.Exp_time   = exp_time;

endmodule

// File: tb/tb_pixel_controller.sv
// Directed bench for pixel_controller: reset, frame timing, exposure saturation, Init handling.
module tb_pixel_controller;

  logic clk;
  logic reset;
  int   n_assert;
  int   n_fail;

  pixel_controller_if #(.CNT_W(8)) bus ();

  pixel_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag, input logic [31:0] exp_time);
    chk({tag, " Erase"}, 32'(bus.Erase), 1);
    chk({tag, " Expose"}, 32'(bus.Expose), 0);
    chk({tag, " ADC"}, 32'(bus.ADC), 0);
    chk({tag, " NRE_1"}, 32'(bus.NRE_1), 1);
    chk({tag, " NRE_2"}, 32'(bus.NRE_2), 1);
    chk({tag, " Busy"}, 32'(bus.Busy), 0);
    chk({tag, " Exp_time"}, 32'(bus.Exp_time), exp_time);
  endtask

  // Called one cycle after Init was sampled; walks the frame until Frame_done.
  // poke >= 0 pulses Init and Exp_increase for one cycle at that loop index.
  task automatic run_frame(input int poke, output int n_er, output int n_ex, output int n_adc,
                           output int n_r1, output int n_r2, output int n_busy,
                           output int n_ovl, output bit seen);
    int act;
    n_er = 0; n_ex = 0; n_adc = 0; n_r1 = 0; n_r2 = 0; n_busy = 0; n_ovl = 0; seen = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (bus.Frame_done) begin
        seen = 1'b1;
        break;
      end
      if (bus.Busy) n_busy++;
      if (bus.Busy && bus.Erase) n_er++;
      if (bus.Expose) n_ex++;
      if (bus.ADC) n_adc++;
      if (!bus.NRE_1) n_r1++;
      if (!bus.NRE_2) n_r2++;
      act = int'(bus.Erase) + int'(bus.Expose) + int'(bus.ADC) + int'(!bus.NRE_1)
          + int'(!bus.NRE_2);
      if (act > 1) n_ovl++;
      if (poke >= 0 && c == poke) begin
        bus.Init = 1'b1;
        bus.Exp_increase = 1'b1;
      end else if (poke >= 0 && c == poke + 1) begin
        bus.Init = 1'b0;
        bus.Exp_increase = 1'b0;
      end
      tick();
    end
  endtask

  int n_er, n_ex, n_adc, n_r1, n_r2, n_busy, n_ovl;
  bit seen;

  initial begin
    n_assert = 0;
    n_fail   = 0;
    reset = 1'b1;
    bus.Init = 1'b0;
    bus.Exp_increase = 1'b0;
    bus.Exp_decrease = 1'b0;
    tick();
    tick();
    chk_idle("reset", 16);
    chk("reset Frame_done", 32'(bus.Frame_done), 0);
    #3 reset = 1'b0;
    tick();

    // Default frame: 5 + 16 + 255 + 4 + 4 = 284 busy cycles.
    bus.Init = 1'b1;
    tick();
    bus.Init = 1'b0;
    chk("start Busy", 32'(bus.Busy), 1);
    chk("start Erase", 32'(bus.Erase), 1);
    run_frame(-1, n_er, n_ex, n_adc, n_r1, n_r2, n_busy, n_ovl, seen);
    chk("dflt done seen", 32'(seen), 1);
    chk("dflt erase len", n_er, 5);
    chk("dflt expose len", n_ex, 16);
    chk("dflt adc len", n_adc, 255);
    chk("dflt nre1 len", n_r1, 4);
    chk("dflt nre2 len", n_r2, 4);
    chk("dflt busy len", n_busy, 284);
    chk("dflt overlap", n_ovl, 0);
    chk("done Busy", 32'(bus.Busy), 0);
    chk("done Erase", 32'(bus.Erase), 1);
    tick();
    chk("done pulse width", 32'(bus.Frame_done), 0);

    // Exposure saturation.
    bus.Exp_increase = 1'b1;
    tick();
    chk("inc one", 32'(bus.Exp_time), 17);
    repeat (39) tick();
    chk("inc sat", 32'(bus.Exp_time), 30);
    bus.Exp_increase = 1'b0;
    bus.Exp_decrease = 1'b1;
    tick();
    chk("dec one", 32'(bus.Exp_time), 29);
    repeat (39) tick();
    chk("dec sat", 32'(bus.Exp_time), 2);
    bus.Exp_increase = 1'b1;
    repeat (3) tick();
    chk("both at min", 32'(bus.Exp_time), 2);
    bus.Exp_decrease = 1'b0;
    tick();
    chk("inc to 3", 32'(bus.Exp_time), 3);
    bus.Exp_decrease = 1'b1;
    repeat (2) tick();
    chk("both at 3", 32'(bus.Exp_time), 3);
    bus.Exp_increase = 1'b0;
    bus.Exp_decrease = 1'b0;

    // Init and Exp_increase during EXPOSE are ignored: 5 + 3 + 255 + 8 = 271.
    bus.Init = 1'b1;
    tick();
    bus.Init = 1'b0;
    run_frame(6, n_er, n_ex, n_adc, n_r1, n_r2, n_busy, n_ovl, seen);
    chk("ign done seen", 32'(seen), 1);
    chk("ign expose len", n_ex, 3);
    chk("ign busy len", n_busy, 271);
    chk("ign Exp_time", 32'(bus.Exp_time), 3);
    tick();
    chk("ign no restart", 32'(bus.Busy), 0);

    // Back-to-back frames with Init held.
    bus.Init = 1'b1;
    tick();
    run_frame(-1, n_er, n_ex, n_adc, n_r1, n_r2, n_busy, n_ovl, seen);
    chk("b2b first done", 32'(seen), 1);
    chk("b2b first expose", n_ex, 3);
    chk("b2b first busy", n_busy, 271);
    tick();
    bus.Init = 1'b0;
    chk("b2b restart Busy", 32'(bus.Busy), 1);
    chk("b2b restart Done", 32'(bus.Frame_done), 0);
    run_frame(-1, n_er, n_ex, n_adc, n_r1, n_r2, n_busy, n_ovl, seen);
    chk("b2b second done", 32'(seen), 1);
    chk("b2b second expose", n_ex, 3);
    chk("b2b second erase", n_er, 5);
    chk("b2b overlap", n_ovl, 0);
    tick();

    // Reset in the middle of CONVERT.
    bus.Init = 1'b1;
    tick();
    bus.Init = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (bus.ADC) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    chk("reach CONVERT", 32'(seen), 1);
    repeat (10) tick();
    chk("mid CONVERT ADC", 32'(bus.ADC), 1);
    #2 reset = 1'b1;
    #1;
    chk_idle("async reset", 16);
    tick();
    chk_idle("reset next cycle", 16);
    #3 reset = 1'b0;
    tick();
    chk("post reset Frame_done", 32'(bus.Frame_done), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
